div_16x8_seq: RTL
=================

Name: div_16x8_seq

Overview:
Sequential restoring divider. It is the inverse of the team's combinational 8x8 multipliers: a 16-bit dividend divided by an 8-bit divisor gives a 16-bit quotient and an 8-bit remainder. One quotient bit is produced per clock. It sits behind a valid/ready handshake so that datapath blocks can hand it work and collect results under backpressure.

Parameters:
N_W, 16, dividend and quotient width.
D_W, 8, divisor and remainder width. Must be ≤ N_W.

Ports:
clk  input  1  sole clock, rising edge
rst_n  input  1  reset, synchronous, active-low
in_valid  input  1  operands valid
in_ready  output  1  block can accept operands
dividend  input  N_W  unsigned dividend
divisor  input  D_W  unsigned divisor
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
quotient  output  N_W  unsigned quotient
remainder  output  D_W  unsigned remainder
div_zero  output  1  divisor was zero; see Optional Feature

Behaviour:
- Reset: rst_n sampled low at a rising edge forces all of the following.
  - state=IDLE, in_ready=1, out_valid=0, div_zero=0.
  - quotient=0, remainder=0, step counter=0.
  - Reset mid-operation aborts the operation. No result is emitted.
- States: IDLE, BUSY, DONE.
- in_ready=1 only in IDLE. out_valid=1 only in DONE.
- IDLE:
  - Accept occurs on in_valid & in_ready at an edge.
  - On accept, latch dividend into the shift register, latch divisor, clear the partial remainder (D_W+1 bits) and the counter, then go to BUSY.
- BUSY, each edge:
  - r = {r[D_W-1:0], q_msb}; shift the quotient register left.
  - If r >= divisor: r -= divisor and the quotient LSB = 1. Otherwise the LSB = 0.
  - Counter increments. After step N_W-1, go to DONE.
- Latency: accept at edge 0; steps at edges 1..N_W; out_valid=1 starting right after edge N_W (16 cycles).
- DONE:
  - quotient and remainder are held stable while out_valid=1 and out_ready=0.
  - On out_valid & out_ready at an edge, go to IDLE.
  - The next accept is possible at the following edge; there is no same-cycle turnaround.
- in_valid in BUSY or DONE is ignored. Operands are not sampled.
- Divisor=0 without the macro: the datapath is overridden.
  - quotient = all ones; remainder = dividend[D_W-1:0].
  - Normal N_W-cycle latency applies.
- Invariant for divisor≠0: dividend = quotient*divisor + remainder, and remainder < divisor.

Optional Feature:
Macro DIV_ZERO_DETECT_EN.
- Defined:
  - Accept with divisor==0 goes IDLE→DONE directly, so out_valid is high 1 cycle after accept.
  - Result is quotient all ones, remainder = dividend[D_W-1:0], div_zero=1.
  - div_zero is held with the result and cleared on handshake or reset.
- Not defined:
  - div_zero is tied to 0.
  - The zero-divisor result is as in Behaviour, with full latency.

Decomposition:
- Shared package div_pkg holds:
  - state enum (IDLE, BUSY, DONE);
  - localparam CNT_W = $clog2(N_W);
  - constant for the zero-divisor quotient (all ones).
- One natural sub-module: div_step.
  - Combinational single restoring step.
  - Inputs: r, incoming bit, divisor. Outputs: next r, quotient bit.
  - Reusable by a future unrolled/pipelined divider.

Test Plan:
- 1000 / 7 → quotient 142, remainder 6. out_valid rises exactly 16 cycles after the accept edge.
- 65535 / 255 → 257 rem 0; 100 / 200 → 0 rem 100; 255 / 1 → 255 rem 0.
- Backpressure: compute 0x1234 / 0x10 with out_ready=0 for 5 cycles.
  - Expect quotient 0x0123, remainder 0x04, held stable.
  - in_ready stays 0 and a second in_valid is ignored.
- Divisor 0 with dividend 0x1234 → quotient 0xFFFF, remainder 0x34.
  - Without the macro: div_zero=0, latency 16.
  - With DIV_ZERO_DETECT_EN: div_zero=1, latency 1.
- Reset mid-BUSY (rst_n=0 at step 8):
  - Next edge: state IDLE, in_ready=1, out_valid=0, outputs 0.
  - A subsequent 50 / 3 gives 16 rem 2.
- Random back-to-back: 1000 random operand pairs with random out_ready.
  - Check the invariant.
  - Check no result is lost or duplicated.

Source files
------------

// File: rtl/div_pkg.sv
// Shared types and constants for the sequential restoring divider.
// Widths here are the build widths the divider is instantiated with.
package div_pkg;

   localparam int DIV_N_W = 16;
   localparam int DIV_D_W = 8;
   localparam int CNT_W   = $clog2(DIV_N_W);

   // Quotient reported for a zero divisor.
   localparam logic [DIV_N_W-1:0] QUOT_DIV0 = '1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } div_state_e;

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step: shift in the next dividend bit,
// subtract the divisor when it fits and report the resulting quotient bit.
module div_step #(
   parameter int D_W = 8
) (
   input  logic [D_W-1:0] r_i,
   input  logic           bit_i,
   input  logic [D_W-1:0] divisor_i,
   output logic [D_W-1:0] r_o,
   output logic           q_bit_o
);

   logic [D_W:0] r_shift;

   always_comb begin
      r_shift = {r_i, bit_i};
      q_bit_o = (r_shift >= {1'b0, divisor_i});
      // A successful subtraction always leaves less than the divisor, so the
      // low D_W bits of the difference are exact.
      if (q_bit_o) begin
         r_o = r_shift[D_W-1:0] - divisor_i;
      end else begin
         r_o = r_shift[D_W-1:0];
      end
   end

endmodule

// File: rtl/div_16x8_seq.sv
// Sequential restoring divider, one quotient bit per clock: N_W cycles from accept
// to out_valid (one cycle for a zero divisor when DIV_ZERO_DETECT_EN is defined).
// Backpressure: result is held in DONE until out_ready; in_ready only while idle.
module div_16x8_seq
   import div_pkg::*;
#(
   parameter int N_W = DIV_N_W,
   parameter int D_W = DIV_D_W
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [N_W-1:0] dividend,
   input  logic [D_W-1:0] divisor,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [N_W-1:0] quotient,
   output logic [D_W-1:0] remainder,
   output logic           div_zero
);

   div_state_e       state_q, state_d;
   logic [N_W-1:0]   q_q, q_d;
   logic [D_W-1:0]   r_q, r_d;
   logic [D_W-1:0]   dvs_q, dvs_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [D_W-1:0]   r_step;
   logic             q_bit;

   // The quotient register doubles as the dividend shifter: its MSB feeds the
   // partial remainder while quotient bits enter at the LSB.
   div_step #(.D_W(D_W)) u_step (
      .r_i       (r_q),
      .bit_i     (q_q[N_W-1]),
      .divisor_i (dvs_q),
      .r_o       (r_step),
      .q_bit_o   (q_bit)
   );

`ifdef DIV_ZERO_DETECT_EN
   logic div_zero_q, div_zero_d;
`endif

   always_comb begin
      state_d = state_q;
      q_d     = q_q;
      r_d     = r_q;
      dvs_d   = dvs_q;
      cnt_d   = cnt_q;
`ifdef DIV_ZERO_DETECT_EN
      div_zero_d = div_zero_q;
`endif
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               q_d     = dividend;
               dvs_d   = divisor;
               r_d     = '0;
               cnt_d   = '0;
               state_d = BUSY;
`ifdef DIV_ZERO_DETECT_EN
               if (divisor == '0) begin
                  q_d        = QUOT_DIV0;
                  r_d        = dividend[D_W-1:0];
                  div_zero_d = 1'b1;
                  state_d    = DONE;
               end
`endif
            end
         end
         BUSY: begin
            q_d   = {q_q[N_W-2:0], q_bit};
            r_d   = r_step;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_W'(N_W - 1)) begin
               state_d = DONE;
               // With a zero divisor the remainder path already ends holding
               // the dividend's low bits; only the quotient is forced.
               if (dvs_q == '0) begin
                  q_d = QUOT_DIV0;
               end
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
`ifdef DIV_ZERO_DETECT_EN
               div_zero_d = 1'b0;
`endif
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         q_q     <= '0;
         r_q     <= '0;
         dvs_q   <= '0;
         cnt_q   <= '0;
`ifdef DIV_ZERO_DETECT_EN
         div_zero_q <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         q_q     <= q_d;
         r_q     <= r_d;
         dvs_q   <= dvs_d;
         cnt_q   <= cnt_d;
`ifdef DIV_ZERO_DETECT_EN
         div_zero_q <= div_zero_d;
`endif
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign quotient  = q_q;
   assign remainder = r_q;
`ifdef DIV_ZERO_DETECT_EN
   assign div_zero  = div_zero_q;
`else
   assign div_zero  = 1'b0;
`endif

endmodule
